// File: rtl/uart_tx_pkg.sv
// Shared UART encodings: serializer FSM states, parity sense and line idle level.
// Imported by both the TX serializer and the RX deserializer so the two always agree.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5
  } tx_state_e;

  localparam logic PAR_EVEN      = 1'b0;
  localparam logic PAR_ODD       = 1'b1;
  localparam logic TX_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// Serial bit timer: counts PRESCALE cycles per bit and strobes o_bit_end on the last cycle of each bit.
// Reload value is captured on i_load; while not running the counter sits at the reload value.
module uart_bit_timer #(
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_load,
  input  logic                      i_run,
  input  logic [PRESCALE_WIDTH-1:0] i_prescale,
  output logic                      o_bit_end
);

  logic [PRESCALE_WIDTH-1:0] r_reload;
  logic [PRESCALE_WIDTH-1:0] r_cnt;
  logic [PRESCALE_WIDTH-1:0] w_load_val;

  // A prescale of zero behaves like one cycle per bit.
  assign w_load_val = (i_prescale == '0) ? '0 : (i_prescale - PRESCALE_WIDTH'(1));
  assign o_bit_end  = i_run && (r_cnt == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_reload <= '0;
      r_cnt    <= '0;
    end else if (i_load) begin
      r_reload <= w_load_val;
      r_cnt    <= w_load_val;
    end else if (o_bit_end) begin
      r_cnt <= r_reload;
    end else if (i_run) begin
      r_cnt <= r_cnt - PRESCALE_WIDTH'(1);
    end else begin
      r_cnt <= r_reload;
    end
  end

endmodule

// File: rtl/uart_tx_frame_serializer.sv
// UART frame serializer: start, 1..DATA_LENGTH data bits, optional parity, 1-2 stop bits; first bit on TX_OUT one cycle after accept.
// Accepts only in IDLE (ready); Data_Valid while busy is dropped, so upstream holds it until ready.
module uart_tx_frame_serializer
  import uart_tx_pkg::*;
#(
  parameter int  DATA_LENGTH    = 8,
  parameter int  PRESCALE_WIDTH = 8,
  localparam int LW             = $clog2(DATA_LENGTH) + 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_LENGTH-1:0]    P_DATA,
  input  logic                      Data_Valid,
  output logic                      ready,
  input  logic [LW-1:0]             CFG_LEN,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic                      MSB_FIRST,
  input  logic                      STOP2,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  output logic                      TX_OUT,
  output logic                      busy,
  output logic                      frame_done
);

  tx_state_e r_state;
  tx_state_e w_next;

  logic [DATA_LENGTH-1:0] r_shift;
  logic [DATA_LENGTH-1:0] w_shift_d;
  logic [LW-1:0]          r_dcnt;
  logic [LW-1:0]          w_len;
  logic [LW-1:0]          w_sh_amt;
  logic                   r_par;
  logic                   w_par_d;
  logic                   r_par_en;
  logic                   r_msb;
  logic                   r_stop2;
  logic                   r_tx;
  logic                   r_busy;
  logic                   r_done;
  logic                   w_tx_d;
  logic                   w_accept;
  logic                   w_run;
  logic                   w_bit_end;
  logic                   w_cur_bit;
  logic                   w_cur_bit_d;
  logic                   w_last_data;

  assign ready      = (r_state == ST_IDLE);
  assign w_accept   = Data_Valid && ready;
  assign w_run      = (r_state != ST_IDLE);
  assign TX_OUT     = r_tx;
  assign busy       = r_busy;
  assign frame_done = r_done;

  // Out-of-range lengths fall back to the full word.
  assign w_len = ((CFG_LEN == '0) || (CFG_LEN > LW'(DATA_LENGTH))) ? LW'(DATA_LENGTH) : CFG_LEN;
  // MSB-first words are pre-aligned to the top so the outgoing bit is always at a fixed position.
  assign w_sh_amt = LW'(DATA_LENGTH) - w_len;

  assign w_cur_bit   = r_msb ? r_shift[DATA_LENGTH-1] : r_shift[0];
  assign w_cur_bit_d = r_msb ? w_shift_d[DATA_LENGTH-1] : w_shift_d[0];
  assign w_last_data = (r_dcnt == LW'(1));

  uart_bit_timer #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_bit_timer (
    .i_clk     (CLK),
    .i_rst     (RST),
    .i_load    (w_accept),
    .i_run     (w_run),
    .i_prescale(PRESCALE),
    .o_bit_end (w_bit_end)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_next = ST_START;
      ST_START:  if (w_bit_end) w_next = ST_DATA;
      ST_DATA:   if (w_bit_end && w_last_data) w_next = r_par_en ? ST_PARITY : ST_STOP1;
      ST_PARITY: if (w_bit_end) w_next = ST_STOP1;
      ST_STOP1:  if (w_bit_end) w_next = r_stop2 ? ST_STOP2 : ST_IDLE;
      ST_STOP2:  if (w_bit_end) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Parity seed is the odd/even sense, so the accumulated value is already the parity bit.
  always_comb begin
    w_shift_d = r_shift;
    w_par_d   = r_par;
    if (w_accept) begin
      w_shift_d = MSB_FIRST ? (P_DATA << w_sh_amt) : P_DATA;
      w_par_d   = (PAR_TYP == PAR_ODD);
    end else if ((r_state == ST_DATA) && w_bit_end) begin
      w_shift_d = r_msb ? {r_shift[DATA_LENGTH-2:0], 1'b0} : {1'b0, r_shift[DATA_LENGTH-1:1]};
      w_par_d   = r_par ^ w_cur_bit;
    end
  end

  always_comb begin
    w_tx_d = TX_IDLE_LEVEL;
    case (w_next)
      ST_START:  w_tx_d = 1'b0;
      ST_DATA:   w_tx_d = w_cur_bit_d;
      ST_PARITY: w_tx_d = w_par_d;
      default:   w_tx_d = TX_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_tx     <= TX_IDLE_LEVEL;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_dcnt   <= '0;
      r_par_en <= 1'b0;
      r_msb    <= 1'b0;
      r_stop2  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_tx    <= w_tx_d;
      r_busy  <= (w_next != ST_IDLE);
      r_done  <= (r_state != ST_IDLE) && (w_next == ST_IDLE);
      r_shift <= w_shift_d;
      r_par   <= w_par_d;
      if (w_accept) begin
        r_dcnt   <= w_len;
        r_par_en <= PAR_EN;
        r_msb    <= MSB_FIRST;
        r_stop2  <= STOP2;
      end else if ((r_state == ST_DATA) && w_bit_end) begin
        r_dcnt <= r_dcnt - LW'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_serializer.sv
// Scoreboard bench: stimulus pushes the ideal frame (bit list, bit period) for every accepted word;
// a monitor samples the line on the falling edge and compares whole frames as busy drops.
module tb_uart_tx_frame_serializer;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       ready;
  logic [3:0] CFG_LEN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       MSB_FIRST;
  logic       STOP2;
  logic [7:0] PRESCALE;
  logic       TX_OUT;
  logic       busy;
  logic       frame_done;

  typedef struct {
    int          nbits;
    logic [15:0] bits;
    int          p;
    bit          abort;
    int          gap;
  } frame_t;

  frame_t exp_q[$];
  int     n_checks = 0;
  int     n_pass   = 0;
  bit     mon_en   = 1'b0;

  uart_tx_frame_serializer #(.DATA_LENGTH(8), .PRESCALE_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid), .ready(ready),
    .CFG_LEN(CFG_LEN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .MSB_FIRST(MSB_FIRST),
    .STOP2(STOP2), .PRESCALE(PRESCALE), .TX_OUT(TX_OUT), .busy(busy), .frame_done(frame_done)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Ideal frame built straight from the UART framing rules.
  function automatic frame_t model(input logic [7:0] d, input logic [3:0] len, input bit pe,
                                   input bit pt, input bit msb, input bit s2, input logic [7:0] ps,
                                   input int gap, input bit abort);
    frame_t f;
    int     l;
    int     n;
    bit     x;
    l      = (len == 0 || len > 8) ? 8 : int'(len);
    f.p    = (ps == 0) ? 1 : int'(ps);
    f.bits = '1;
    n      = 0;
    x      = 1'b0;
    f.bits[n] = 1'b0;
    n++;
    for (int i = 0; i < l; i++) begin
      bit b;
      b = msb ? d[l-1-i] : d[i];
      f.bits[n] = b;
      x = x ^ b;
      n++;
    end
    if (pe) begin
      f.bits[n] = pt ? ~x : x;
      n++;
    end
    f.bits[n] = 1'b1;
    n++;
    if (s2) begin
      f.bits[n] = 1'b1;
      n++;
    end
    f.nbits = n;
    f.gap   = gap;
    f.abort = abort;
    return f;
  endfunction

  // Called #1 after a rising edge; returns #1 after the accept edge.
  task automatic send(input logic [7:0] d, input logic [3:0] len, input bit pe, input bit pt,
                      input bit msb, input bit s2, input logic [7:0] ps, input bit hold,
                      input int gap, input bit abort);
    int t;
    P_DATA = d; CFG_LEN = len; PAR_EN = pe; PAR_TYP = pt;
    MSB_FIRST = msb; STOP2 = s2; PRESCALE = ps; Data_Valid = 1'b1;
    t = 0;
    while (!ready && t < 5000) begin
      @(posedge CLK); #1;
      t++;
    end
    check("accept_wait", {31'd0, ready}, 32'd1);
    if (!ready) begin
      Data_Valid = 1'b0;
      return;
    end
    exp_q.push_back(model(d, len, pe, pt, msb, s2, ps, gap, abort));
    @(posedge CLK); #1;
    if (!hold) Data_Valid = 1'b0;
  endtask

  initial begin : monitor
    frame_t cur;
    bit     in_frame;
    bit     wave_ok;
    int     cyc;
    int     idle_cnt;
    in_frame = 1'b0; wave_ok = 1'b0; cyc = 0; idle_cnt = 0;
    cur = '{nbits: 0, bits: '1, p: 0, abort: 1'b0, gap: -1};
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        check("ready_vs_busy", {31'd0, ready}, {31'd0, !busy});
        if (busy) begin
          if (!in_frame) begin
            if (exp_q.size() == 0) begin
              check("unexpected_frame", 32'd1, {31'd0, RST});
              cur = '{nbits: 0, bits: '1, p: 0, abort: 1'b0, gap: -1};
            end else begin
              cur = exp_q.pop_front();
              if (cur.gap >= 0) check("frame_gap", idle_cnt, cur.gap);
            end
            in_frame = 1'b1; wave_ok = 1'b1; cyc = 0; idle_cnt = 0;
          end
          if (cur.p > 0 && (cyc / cur.p) < cur.nbits) begin
            if (TX_OUT !== cur.bits[cyc / cur.p]) wave_ok = 1'b0;
          end else begin
            wave_ok = 1'b0;
          end
          cyc++;
          check("done_low_busy", {31'd0, frame_done}, 32'd0);
        end else begin
          idle_cnt++;
          if (in_frame) begin
            in_frame = 1'b0;
            check("frame_wave", {31'd0, wave_ok}, 32'd1);
            if (cur.abort) begin
              check("abort_no_done", {31'd0, frame_done}, 32'd0);
            end else begin
              check("frame_done", {31'd0, frame_done}, 32'd1);
              check("busy_len", cyc, cur.p * cur.nbits);
            end
          end else begin
            check("done_idle", {31'd0, frame_done}, 32'd0);
          end
          check("idle_line", {31'd0, TX_OUT}, 32'd1);
        end
      end
    end
  end

  initial begin : stimulus
    int t;
    RST = 1'b1; Data_Valid = 1'b0; P_DATA = '0; CFG_LEN = '0; PAR_EN = 1'b0;
    PAR_TYP = 1'b0; MSB_FIRST = 1'b0; STOP2 = 1'b0; PRESCALE = '0;
    @(posedge CLK); #1;
    mon_en = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    check("rst_tx", {31'd0, TX_OUT}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_done", {31'd0, frame_done}, 32'd0);
    repeat (10) @(posedge CLK);
    #1;

    // 8N1 LSB first, 0xA5, four cycles per bit.
    send(8'hA5, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4, 1'b0, -1, 1'b0);
    // 5 bits MSB first, odd parity, two stop bits, one cycle per bit.
    send(8'hF6, 4'd5, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1, 1'b0, -1, 1'b0);

    // Mid-frame word/config changes and a Data_Valid pulse must be ignored.
    send(8'h5A, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 8'd4, 1'b0, -1, 1'b0);
    repeat (5) @(posedge CLK);
    #1;
    P_DATA = 8'hC3; PRESCALE = 8'd1; CFG_LEN = 4'd3; MSB_FIRST = 1'b1; Data_Valid = 1'b1;
    check("midframe_ready", {31'd0, ready}, 32'd0);
    @(posedge CLK); #1;
    Data_Valid = 1'b0;
    check("midframe_busy", {31'd0, busy}, 32'd1);

    // Back-to-back with Data_Valid held: exactly one idle cycle between frames.
    send(8'h00, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 1'b1, -1, 1'b0);
    send(8'hFF, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0, 1, 1'b0);

    // Zero length and zero prescale clamp to 8 bits at one cycle per bit.
    send(8'h3C, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, -1, 1'b0);
    // Next frame is aborted by reset during its fourth bit.
    send(8'h96, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4, 1'b0, -1, 1'b1);
    repeat (13) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    check("abort_tx", {31'd0, TX_OUT}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(posedge CLK);
    #1;

    for (int k = 0; k < 24; k++) begin
      send(8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 8'($urandom_range(0, 4)), 1'b0, -1, 1'b0);
      repeat ($urandom_range(0, 3)) @(posedge CLK);
      #1;
    end

    t = 0;
    while ((exp_q.size() != 0 || busy) && t < 20000) begin
      @(posedge CLK); #1;
      t++;
    end
    check("drain", exp_q.size(), 32'd0);
    repeat (4) @(posedge CLK);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
